// File: rtl/mips_multicycle_control.sv
// Moore control FSM for a multi-cycle MIPS datapath: sequences fetch/decode/execute,
// handshakes with a variable-latency unified memory, traps on unknown opcodes.
module mips_multicycle_control #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           opcode,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_write,
    output logic                 i_or_d,
    output logic                 ir_write,
    output logic                 pc_en,
    output logic [1:0]           pc_source,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic                 instr_done,
    output logic                 illegal_op,
    output logic [3:0]           state,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] retired_count
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11,
        TRAP      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_reg, state_next;
    logic                   illegal_reg;
    logic [CNT_WIDTH-1:0]   cycle_reg, retired_reg;
    logic                   retire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= FETCH;
            illegal_reg <= 1'b0;
            cycle_reg   <= '0;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg != TRAP)
                cycle_reg <= cycle_reg + CNT_ONE;
            if (retire)
                retired_reg <= retired_reg + CNT_ONE;
            if (state_next == TRAP)
                illegal_reg <= 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH:     if (mem_ready) state_next = DECODE;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:      state_next = R_EXEC;
                    OP_LW, OP_SW:  state_next = MEM_ADDR;
                    OP_BEQ:        state_next = BRANCH;
                    OP_ADDI:       state_next = ADDI_EXEC;
                    OP_J:          state_next = JUMP;
                    default:       state_next = TRAP;
                endcase
            end
            // IR is stable here, but an opcode that is neither lw nor sw still traps
            MEM_ADDR: begin
                if (opcode == OP_LW)
                    state_next = MEM_READ;
                else if (opcode == OP_SW)
                    state_next = MEM_WRITE;
                else
                    state_next = TRAP;
            end
            MEM_READ:  if (mem_ready) state_next = MEM_WB;
            MEM_WB:    state_next = FETCH;
            MEM_WRITE: if (mem_ready) state_next = FETCH;
            R_EXEC:    state_next = R_WB;
            R_WB:      state_next = FETCH;
            BRANCH:    state_next = FETCH;
            JUMP:      state_next = FETCH;
            ADDI_EXEC: state_next = ADDI_WB;
            ADDI_WB:   state_next = FETCH;
            TRAP:      state_next = TRAP;
            default:   state_next = TRAP;
        endcase
    end

    // Everything is held at 0 while reset is asserted, selects included
    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_source  = 2'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 2'd0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        retire     = 1'b0;
        if (reset) begin
            case (state_reg)
                FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'd1;
                    ir_write  = mem_ready;
                    pc_en     = mem_ready;
                end
                DECODE:    alu_src_b = 2'd3;
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                end
                MEM_READ: begin
                    mem_req = 1'b1;
                    i_or_d  = 1'b1;
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    retire     = 1'b1;
                end
                MEM_WRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    retire    = mem_ready;
                end
                R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'd2;
                end
                R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    retire    = 1'b1;
                end
                BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'd1;
                    pc_source = 2'd1;
                    pc_en     = zero;
                    retire    = 1'b1;
                end
                JUMP: begin
                    pc_source = 2'd2;
                    pc_en     = 1'b1;
                    retire    = 1'b1;
                end
                ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                end
                ADDI_WB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign instr_done    = retire;
    assign illegal_op    = illegal_reg;
    assign state         = state_reg;
    assign cycle_count   = cycle_reg;
    assign retired_count = retired_reg;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: expands each directed instruction into its expected
// per-cycle phases and checks a 32-bit and a 4-bit counter instance against that model.
module tb_mips_multicycle_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [5:0] opcode;
    logic       zero, mem_ready;

    logic        a_mem_req, a_mem_write, a_i_or_d, a_ir_write, a_pc_en;
    logic [1:0]  a_pc_source, a_alu_src_b, a_alu_op;
    logic        a_alu_src_a, a_reg_dst, a_mem_to_reg, a_reg_write, a_instr_done, a_illegal_op;
    logic [3:0]  a_state;
    logic [31:0] a_cyc, a_ret;

    logic        b_mem_req, b_mem_write, b_i_or_d, b_ir_write, b_pc_en;
    logic [1:0]  b_pc_source, b_alu_src_b, b_alu_op;
    logic        b_alu_src_a, b_reg_dst, b_mem_to_reg, b_reg_write, b_instr_done, b_illegal_op;
    logic [3:0]  b_state;
    logic [3:0]  b_cyc, b_ret;

    mips_multicycle_control #(.CNT_WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(a_mem_req), .mem_write(a_mem_write), .i_or_d(a_i_or_d),
        .ir_write(a_ir_write), .pc_en(a_pc_en), .pc_source(a_pc_source),
        .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .alu_op(a_alu_op),
        .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg), .reg_write(a_reg_write),
        .instr_done(a_instr_done), .illegal_op(a_illegal_op), .state(a_state),
        .cycle_count(a_cyc), .retired_count(a_ret)
    );

    mips_multicycle_control #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(b_mem_req), .mem_write(b_mem_write), .i_or_d(b_i_or_d),
        .ir_write(b_ir_write), .pc_en(b_pc_en), .pc_source(b_pc_source),
        .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_op(b_alu_op),
        .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg), .reg_write(b_reg_write),
        .instr_done(b_instr_done), .illegal_op(b_illegal_op), .state(b_state),
        .cycle_count(b_cyc), .retired_count(b_ret)
    );

    logic [20:0] a_bus, b_bus;
    assign a_bus = {a_state, a_mem_req, a_mem_write, a_i_or_d, a_ir_write, a_pc_en,
                    a_pc_source, a_alu_src_a, a_alu_src_b, a_alu_op,
                    a_reg_dst, a_mem_to_reg, a_reg_write, a_instr_done, a_illegal_op};
    assign b_bus = {b_state, b_mem_req, b_mem_write, b_i_or_d, b_ir_write, b_pc_en,
                    b_pc_source, b_alu_src_a, b_alu_src_b, b_alu_op,
                    b_reg_dst, b_mem_to_reg, b_reg_write, b_instr_done, b_illegal_op};

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_cyc, m_ret;
    logic [20:0] exp_bus;
    bit          exp_valid = 0;
    logic [5:0]  cur_op;
    bit          cur_zero;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Expected outputs for one cycle, straight from the per-state output table
    function automatic logic [20:0] expect_outs(input int st, input bit rdy, input bit z,
                                                input bit done, input bit ill);
        logic mr = 0, mw = 0, iod = 0, irw = 0, pce = 0, asa = 0, rd = 0, m2r = 0, rw = 0;
        logic [1:0] ps = 0, asb = 0, aop = 0;
        case (st)
            0:  begin mr = 1; asb = 1; irw = rdy; pce = rdy; end
            1:  asb = 3;
            2:  begin asa = 1; asb = 2; end
            3:  begin mr = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mr = 1; mw = 1; iod = 1; end
            6:  begin asa = 1; aop = 2; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 1; ps = 1; pce = z; end
            9:  begin ps = 2; pce = 1; end
            10: begin asa = 1; asb = 2; end
            11: rw = 1;
            default: ;
        endcase
        return {4'(st), mr, mw, iod, irw, pce, ps, asa, asb, aop, rd, m2r, rw, done, ill};
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            chk("outs32", a_bus, exp_bus);
            chk("outs4", b_bus, exp_bus);
            chk("cycle32", a_cyc, m_cyc);
            chk("retired32", a_ret, m_ret);
            chk("cycle4", b_cyc, m_cyc[3:0]);
            chk("retired4", b_ret, m_ret[3:0]);
        end
    end

    // One cycle in phase st; memory phases honour rdy, others get random mem_ready/zero
    task automatic step(input int st, input bit rdy, input bit last);
        bit mem_phase;
        mem_phase = (st == 0) || (st == 3) || (st == 5);
        mem_ready = mem_phase ? rdy : 1'($urandom_range(1));
        zero      = (st == 8) ? cur_zero : 1'($urandom_range(1));
        opcode    = (st == 0) ? 6'($urandom_range(63)) : cur_op;
        exp_bus   = expect_outs(st, mem_ready, zero, last, st == 12);
        exp_valid = 1;
        @(posedge clk);
        #1;
        if (st != 12) m_cyc = m_cyc + 32'd1;
        if (last)     m_ret = m_ret + 32'd1;
    endtask

    task automatic fetch_decode(input int fw);
        repeat (fw) step(0, 0, 0);
        step(0, 1, 0);
        step(1, 0, 0);
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                             input bit z, input int trap_cycles);
        logic [31:0] start;
        start    = m_cyc;
        cur_op   = op;
        cur_zero = z;
        fetch_decode(fw);
        case (op)
            6'h00: begin step(6, 0, 0); step(7, 0, 1); end
            6'h23: begin
                step(2, 0, 0);
                repeat (mw) step(3, 0, 0);
                step(3, 1, 0);
                step(4, 0, 1);
            end
            6'h2B: begin
                step(2, 0, 0);
                repeat (mw) step(5, 0, 0);
                step(5, 1, 1);
            end
            6'h04: step(8, 0, 1);
            6'h08: begin step(10, 0, 0); step(11, 0, 1); end
            6'h02: step(9, 0, 1);
            default: repeat (trap_cycles) step(12, 0, 0);
        endcase
        $display("instr op=%02h zero=%0d cycles=%0d retired=%0d", op, z, m_cyc - start, m_ret);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_outs32"}, a_bus, 0);
        chk({tag, "_outs4"}, b_bus, 0);
        chk({tag, "_cycle32"}, a_cyc, 0);
        chk({tag, "_retired32"}, a_ret, 0);
        chk({tag, "_cycle4"}, b_cyc, 0);
        chk({tag, "_retired4"}, b_ret, 0);
    endtask

    // Called just after a rising edge; releases reset just after a later rising edge
    task automatic do_reset(input string tag);
        exp_valid = 0;
        reset     = 1'b0;
        mem_ready = 1'b1;
        #3;
        check_reset_outputs(tag);
        @(posedge clk);
        #1;
        check_reset_outputs({tag, "_held"});
        m_cyc = 0;
        m_ret = 0;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b0;
        m_cyc = 0; m_ret = 0; cur_op = 6'h00; cur_zero = 0;
        #2;
        do_reset("por");

        run_instr(6'h00, 0, 0, 0, 0);
        chk("rtype_cycles", a_cyc, 32'd4);
        chk("rtype_retired", a_ret, 32'd1);

        run_instr(6'h23, 2, 3, 0, 0);
        chk("lw_wait_latency", a_cyc - 32'd4, 32'd10);
        chk("lw_retired", a_ret, 32'd2);

        run_instr(6'h04, 0, 0, 1, 0);
        run_instr(6'h04, 0, 0, 0, 0);
        chk("beq_pair_cycles", a_cyc, 32'd20);
        run_instr(6'h2B, 1, 2, 0, 0);
        run_instr(6'h08, 0, 0, 0, 0);
        run_instr(6'h02, 3, 0, 0, 0);
        run_instr(6'h2B, 0, 0, 0, 0);
        run_instr(6'h23, 0, 0, 0, 0);

        do_reset("pre_trap");
        run_instr(6'h3F, 0, 0, 0, 20);
        chk("trap_state", a_state, 4'd12);
        chk("trap_flag", a_illegal_op, 1'b1);
        chk("trap_cycle_frozen", a_cyc, 32'd2);
        chk("trap_retired", a_ret, 32'd0);
        do_reset("trap_release");
        run_instr(6'h00, 1, 0, 0, 0);
        chk("after_trap_cycles", a_cyc, 32'd5);

        // Reset asserted mid-store while memory is stalled
        cur_op = 6'h2B;
        fetch_decode(0);
        step(2, 0, 0);
        mem_ready = 1'b0;
        opcode    = cur_op;
        exp_bus   = expect_outs(5, 0, zero, 0, 0);
        exp_valid = 1;
        @(negedge clk);
        #2;
        exp_valid = 0;
        reset = 1'b0;
        #1;
        chk("midwr_mem_req", a_mem_req, 1'b0);
        chk("midwr_mem_write", a_mem_write, 1'b0);
        chk("midwr_instr_done", a_instr_done, 1'b0);
        check_reset_outputs("midwr");
        @(posedge clk);
        #1;
        do_reset("midwr_release");
        $display("instr op=2b reset mid-write retired=%0d", a_ret);

        // Five zero-wait jumps fill the 4-bit cycle counter exactly
        repeat (5) run_instr(6'h02, 0, 0, 0, 0);
        chk("wrap_cycle4_full", b_cyc, 4'd15);
        chk("wrap_retired4", b_ret, 4'd5);
        cur_op = 6'h02;
        step(0, 0, 0);
        chk("wrap_cycle4_zero", b_cyc, 4'd0);
        chk("wrap_cycle32", a_cyc, 32'd16);
        exp_valid = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Moore-style control FSM that sequences a multi-cycle MIPS datapath (PC, IR, register file, ALU, unified memory) through fetch/decode/execute/memory/writeback.
- Sits beside `mips_processor`'s datapath and drives every datapath enable and mux select.
- Handles a ready/request handshake with a variable-latency unified memory.
- Traps on unsupported opcodes and exposes cycle and retired-instruction counters for the testbench.

Parameters:
- CNT_WIDTH, 32, width of `cycle_count` and `retired_count`.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- opcode  in  6  IR[31:26], valid from DECODE onward.
- zero  in  1  ALU zero flag, used in BRANCH.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  with `mem_req`: 1 = write, 0 = read.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR.
- pc_en  out  1  PC load enable.
- pc_source  out  2  next-PC select: 0 = ALU, 1 = ALUOut, 2 = jump target.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B select: 0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = imm<<2.
- alu_op  out  2  ALU op class: 0 = add, 1 = sub, 2 = funct, 3 = reserved.
- reg_dst  out  1  write register select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  writeback data select: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write enable.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal_op  out  1  sticky trap flag.
- state  out  4  current state encoding, for debug.
- cycle_count  out  CNT_WIDTH  cycles since reset.
- retired_count  out  CNT_WIDTH  instructions retired since reset.

Behaviour:
- **Reset** (`reset`=0, asynchronous): `state`=FETCH(0); counters 0; `illegal_op`=0; every enable/pulse output forced 0 combinationally while reset is held. Selects are 0.
- **State encoding:** FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11, TRAP=12. Codes 13-15 are unused and go to TRAP on the next edge.
- **Output decode:** outputs are decoded from `state` only, plus `mem_ready` and `zero` where noted. Any output not listed for a state is 0.
- **FETCH:**
  - Asserts `mem_req`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=0, `pc_source`=0.
  - `ir_write` and `pc_en` equal `mem_ready`.
  - Stays in FETCH until `mem_ready`=1, then goes to DECODE.
- **DECODE:** `alu_src_a`=0, `alu_src_b`=3, `alu_op`=0 (branch target into ALUOut). Next state by `opcode`:
  - 0x00 → R_EXEC
  - 0x23, 0x2B → MEM_ADDR
  - 0x04 → BRANCH
  - 0x08 → ADDI_EXEC
  - 0x02 → JUMP
  - anything else → TRAP
- **MEM_ADDR:** `alu_src_a`=1, `alu_src_b`=2, `alu_op`=0. Goes to MEM_READ for 0x23, MEM_WRITE for 0x2B.
- **MEM_READ:** `mem_req`=1, `i_or_d`=1. Waits for `mem_ready`, then goes to MEM_WB.
- **MEM_WB:** `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Retires; goes to FETCH.
- **MEM_WRITE:** `mem_req`=1, `mem_write`=1, `i_or_d`=1. Retires on the cycle `mem_ready`=1, then goes to FETCH.
- **R_EXEC:** `alu_src_a`=1, `alu_src_b`=0, `alu_op`=2. Goes to R_WB.
- **R_WB:** `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Retires; goes to FETCH.
- **BRANCH:** `alu_src_a`=1, `alu_src_b`=0, `alu_op`=1, `pc_source`=1, `pc_en`=`zero`. Retires; goes to FETCH.
- **JUMP:** `pc_source`=2, `pc_en`=1. Retires; goes to FETCH.
- **ADDI_EXEC:** `alu_src_a`=1, `alu_src_b`=2, `alu_op`=0. Goes to ADDI_WB.
- **ADDI_WB:** `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Retires; goes to FETCH.
- **TRAP:** all enables 0; `illegal_op`=1 and sticky. Stays in TRAP until reset.
- **Memory handshake:**
  - `mem_req` is held high until `mem_ready`.
  - `mem_ready` is ignored in states that do not assert `mem_req`.
  - No timeout.
- **Instruction latency with zero-wait memory:**
  - lw = 5 cycles.
  - sw, R-type, addi = 4 cycles.
  - beq, j = 3 cycles.
  - Each memory wait cycle adds 1.
- **`instr_done`:** high for exactly the retiring cycle. `retired_count` increments on that same edge.
- **`cycle_count`:** increments on every edge outside reset and outside TRAP; frozen in TRAP.
- **Counter wrap:** both counters wrap modulo 2^CNT_WIDTH with no flag.
- **Reset mid-instruction:** state returns to FETCH immediately; in-flight `mem_req`/`reg_write` drop the same instant; no partial retire is counted.

Test Plan:
- **R-type, zero-wait memory:** `opcode`=0x00, `mem_ready`=1 → states 0,1,6,7; `reg_write`=1 with `reg_dst`=1 in cycle 4 only; `instr_done` pulse; `retired_count`=1, `cycle_count`=4.
- **lw with wait states:** `opcode`=0x23, `mem_ready` low for 2 cycles in FETCH and 3 cycles in MEM_READ → `mem_req` held throughout the waits; `ir_write` only on the ready cycle; retire at cycle 10 with `mem_to_reg`=1.
- **beq taken vs not taken:** `opcode`=0x04, `zero`=1 → `pc_en`=1 with `pc_source`=1 in BRANCH; same with `zero`=0 → `pc_en`=0; both retire in 3 cycles.
- **Illegal opcode:** `opcode`=0x3F → TRAP (12) at cycle 3; `illegal_op`=1; counters frozen for 20 cycles; release after `reset` pulse returns to FETCH with `illegal_op`=0.
- **Reset mid-operation:** `reset`=0 asserted asynchronously mid-MEM_WRITE with `mem_ready`=0 → `mem_req`/`mem_write` drop immediately; `state`=0; counters 0; no `instr_done`.
- **Counter wrap:** with CNT_WIDTH=4, run 5 j instructions (15 cycles) plus one more cycle → `cycle_count` wraps from 15 to 0; `retired_count`=5.
